// File: rtl/dlat_pkg.sv
// rtl/dlat_pkg.sv - shared constants and helpers for the gated-latch bank
package dlat_pkg;

  // Gate reset pattern in ga,gb,gc,gd order: Q=0, _Q=1.
  localparam logic [3:0] GATE_RST = 4'b1101;

  function automatic int nto_width(input int w);
    return $clog2(4 * w + 1);
  endfunction

endpackage

// File: rtl/dlat_if.sv
// rtl/dlat_if.sv - data, control and status bundle of the latch bank
interface dlat_if #(
  parameter int W = 12
) ();

  localparam int NW = dlat_pkg::nto_width(W);

  logic [W-1:0]  D;
  logic          G;
  logic [W-1:0]  _PC;
  logic [W-1:0]  _PS;
  logic          CLRFLG;
  logic [W-1:0]  Q;
  logic [W-1:0]  _Q;
  logic [NW-1:0] NTO;
  logic          SETTLED;
  logic          HAZARD;
  logic          OSC;

  modport master (
    output D, G, _PC, _PS, CLRFLG,
    input  Q, _Q, NTO, SETTLED, HAZARD, OSC
  );

  modport slave (
    input  D, G, _PC, _PS, CLRFLG,
    output Q, _Q, NTO, SETTLED, HAZARD, OSC
  );

endinterface

// File: rtl/dlat_cell.sv
// rtl/dlat_cell.sv - one latch bit modelled as four unit-delay NAND gates
module dlat_cell
  import dlat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       g,
  input  logic       d,
  input  logic       pc_n,
  input  logic       ps_n,
  output logic [3:0] gates_nx,
  output logic [3:0] gates
);

  // Bit order ga=3, gb=2, gc=1, gd=0; next values feed the bank's change detect.
  always_comb begin
    gates_nx[3] = ~(g & d);
    gates_nx[2] = ~(g & gates[3]);
    gates_nx[1] = ~(gates[3] & gates[0] & ps_n);
    gates_nx[0] = ~(gates[2] & gates[1] & pc_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gates <= GATE_RST;
    end else begin
      gates <= gates_nx;
    end
  end

endmodule

// File: rtl/dlat_bank.sv
// rtl/dlat_bank.sv - bank of W gate-level latches with settle, oscillation and hazard monitors
module dlat_bank
  import dlat_pkg::*;
#(
  parameter int W      = 12,
  parameter int SETTLE = 3,
  parameter int OSCLIM = 16
) (
  input logic   U,
  input logic   RESET,
  dlat_if.slave bus
);

  localparam int NW = nto_width(W);

  logic [3:0]    gates    [W];
  logic [3:0]    gates_nx [W];
  logic [W-1:0]  q;
  logic [W-1:0]  qn;
  logic [NW-1:0] ones;
  logic [NW-1:0] nto;
  logic          change;
  logic [3:0]    settle_cnt;
  logic [7:0]    osc_cnt;
  logic          settled;
  logic          hazard;
  logic          osc;
  logic          g_prev;
  logic          hz_set;
  logic          osc_set;

  for (genvar i = 0; i < W; i++) begin : g_cell
    dlat_cell u_cell (
      .clk      (U),
      .rst      (RESET),
      .g        (bus.G),
      .d        (bus.D[i]),
      .pc_n     (bus._PC[i]),
      .ps_n     (bus._PS[i]),
      .gates_nx (gates_nx[i]),
      .gates    (gates[i])
    );
  end

  // A change is judged on the edge that loads it, so SETTLED counts from that edge.
  always_comb begin
    change = 1'b0;
    ones   = '0;
    q      = '0;
    qn     = '0;
    for (int k = 0; k < W; k++) begin
      change = change | (gates_nx[k] != gates[k]);
      ones   = ones + NW'($countones(gates[k]));
      q[k]   = gates[k][1];
      qn[k]  = gates[k][0];
    end
  end

  assign settled = (settle_cnt == 4'(SETTLE));
  assign hz_set  = (g_prev & ~bus.G & ~settled) | (|(~bus._PC & ~bus._PS));
  assign osc_set = change & (osc_cnt == 8'(OSCLIM - 1));

  always_ff @(posedge U) begin
    if (RESET) begin
      nto        <= NW'(3 * W);
      settle_cnt <= 4'(SETTLE);
      osc_cnt    <= '0;
      hazard     <= 1'b0;
      osc        <= 1'b0;
      g_prev     <= 1'b0;
    end else begin
      nto    <= ones;
      g_prev <= bus.G;
      if (change) begin
        settle_cnt <= '0;
        if (osc_cnt != 8'(OSCLIM)) osc_cnt <= osc_cnt + 8'd1;
      end else begin
        if (!settled) settle_cnt <= settle_cnt + 4'd1;
        osc_cnt <= '0;
      end
      hazard <= hz_set | (hazard & ~bus.CLRFLG);
      osc    <= osc_set | (osc & ~bus.CLRFLG);
    end
  end

  assign bus.Q       = q;
  assign bus._Q      = qn;
  assign bus.NTO     = nto;
  assign bus.SETTLED = settled;
  assign bus.HAZARD  = hazard;
  assign bus.OSC     = osc;

endmodule

// File: doc/dlat_bank.md
DLAT_BANK -- requirements
Module: dlat_bank

Interface
REQ-001 Parameter W, default 12: number of latch bits, 1..32.
REQ-002 Parameter SETTLE, default 3: consecutive change-free U cycles before the bank counts as settled, 1..15.
REQ-003 Parameter OSCLIM, default 16: consecutive changing U cycles before the bank counts as oscillating, 2..255.
REQ-004 U  in  1  system clock; every state element updates on posedge U.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 D  in  W  per-bit data input.
REQ-007 G  in  1  common gate; high makes the latches transparent.
REQ-008 _PC  in  W  per-bit clear, active-low.
REQ-009 _PS  in  W  per-bit preset, active-low.
REQ-010 CLRFLG  in  1  clears the sticky HAZARD and OSC flags.
REQ-011 Q  out  W  latch outputs, gate c of each bit.
REQ-012 _Q  out  W  complement outputs, gate d of each bit.
REQ-013 NTO  out  clog2(4W+1)  registered count of gates at 1, i.e. triodes off.
REQ-014 SETTLED  out  1  high when no gate has changed for SETTLE cycles.
REQ-015 HAZARD  out  1  sticky timing/illegal-input flag.
REQ-016 OSC  out  1  sticky oscillation flag.

Function
REQ-017 Each bit SHALL hold four gate registers ga, gb, gc, gd, each loaded every U edge from the previous-cycle values: ga=~(G&D), gb=~(G&ga), gc=~(ga&gd&_PS), gd=~(gb&gc&_PC).
REQ-018 Q and _Q SHALL be driven directly from gc and gd with no further delay.
REQ-019 NTO SHALL be loaded each cycle with the sum of all 4W gate bits, so it lags the gates by one cycle.
REQ-020 A change SHALL be any difference between the current and the previous-cycle gate vector, taken over all 4W bits.
REQ-021 The settle counter SHALL clear to 0 on a change and otherwise increment, saturating at SETTLE; SETTLED=(count==SETTLE).
REQ-022 The oscillation counter SHALL increment on a change, saturating at OSCLIM, and clear to 0 on a change-free cycle.
REQ-023 OSC SHALL be set on the cycle the oscillation counter reaches OSCLIM.
REQ-024 HAZARD SHALL be set when G goes 1->0 while SETTLED=0, comparing G with its registered previous value.
REQ-025 HAZARD SHALL also be set on any cycle in which some bit has _PC=0 and _PS=0 together.
REQ-026 CLRFLG SHALL clear HAZARD and OSC; if a set condition occurs in the same cycle, the set wins.
REQ-027 Counters SHALL never wrap around.

Reset
REQ-028 While RESET=1, every bit SHALL load ga=1, gb=1, gc=0, gd=1, giving Q=0 and _Q=1.
REQ-029 While RESET=1, NTO SHALL load 3W, the settle counter SHALL load SETTLE (SETTLED=1), the oscillation counter SHALL load 0, HAZARD=0, OSC=0, and the previous-G register SHALL load 0.
REQ-030 RESET SHALL override all inputs, including an operation in progress.
REQ-031 The first post-reset cycle SHALL NOT flag a G falling edge.

Structure
REQ-032 Package dlat_pkg SHALL hold the reset gate constants (4'b1101 in ga..gd order) and a function computing the NTO width.
REQ-033 One sub-module, dlat_cell, SHALL implement the four gate registers of a single bit.
REQ-034 dlat_bank SHALL instantiate W dlat_cell instances and implement the popcount, counters and flags.

Verification (W=4, SETTLE=3, OSCLIM=16)
REQ-035 Reset: hold RESET for 2 cycles with G=0 -> Q=0000, _Q=1111, NTO=12, SETTLED=1, HAZARD=0, OSC=0.
REQ-036 Transparent load: D=1010, G=1 -> Q=1010 after 2 edges, _Q=0101 after 3 edges, SETTLED=1 at edge 6, NTO=8 in steady state.
REQ-037 Hold: after REQ-036 settles, drop G then change D to 0101 -> Q stays 1010, NTO=12, HAZARD=0.
REQ-038 Preset: G=0, Q=0000, pulse _PS[0]=0 for 3 cycles -> Q[0]=1 after 1 edge, _Q[0]=0 after 2 edges, value held after release.
REQ-039 Hazard: G=1, change D, drop G on the next edge -> HAZARD=1 and sticky; CLRFLG pulse -> 0. Driving _PC[2]=_PS[2]=0 -> HAZARD=1.
REQ-040 Oscillation and reset: toggle G every cycle with D=1111 -> OSC=1 by cycle 17; assert RESET mid-toggle -> all REQ-029 values restored on the next edge.
